// File: rtl/sgd_run_ctrl_if.sv
// rtl/sgd_run_ctrl_if.sv - host, loader, engine and RAM signals of the run sequencer
interface sgd_run_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int FEAT_W     = 4,
  parameter int EPOCH_W    = 8,
  parameter int LR_W       = 4
);
  logic                  start;
  logic                  abort;
  logic                  skip_load;
  logic [FEAT_W-1:0]     cfg_feat;
  logic [EPOCH_W-1:0]    cfg_epoch;
  logic [LR_W-1:0]       cfg_lr;
  logic [ADDR_WIDTH-1:0] cfg_num_dp;
  logic                  ser_done;
  logic                  ser_wr_req;
  logic [ADDR_WIDTH-1:0] ser_addr;
  logic                  sgd_done;
  logic [ADDR_WIDTH-1:0] sgd_addr;
  logic                  ser_en;
  logic                  sgd_en;
  logic                  ram_we;
  logic                  ram_oe;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [FEAT_W-1:0]     lat_feat;
  logic [EPOCH_W-1:0]    lat_epoch;
  logic [LR_W-1:0]       lat_lr;
  logic [ADDR_WIDTH-1:0] lat_num_dp;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [1:0]            err_code;
  logic [2:0]            state;

  modport master (
    output start, abort, skip_load, cfg_feat, cfg_epoch, cfg_lr, cfg_num_dp,
    output ser_done, ser_wr_req, ser_addr, sgd_done, sgd_addr,
    input  ser_en, sgd_en, ram_we, ram_oe, ram_addr,
    input  lat_feat, lat_epoch, lat_lr, lat_num_dp,
    input  busy, done, err, err_code, state
  );

  modport slave (
    input  start, abort, skip_load, cfg_feat, cfg_epoch, cfg_lr, cfg_num_dp,
    input  ser_done, ser_wr_req, ser_addr, sgd_done, sgd_addr,
    output ser_en, sgd_en, ram_we, ram_oe, ram_addr,
    output lat_feat, lat_epoch, lat_lr, lat_num_dp,
    output busy, done, err, err_code, state
  );
endinterface

// File: rtl/sgd_run_ctrl.sv
// rtl/sgd_run_ctrl.sv - run sequencer: LOAD -> TRAIN -> WB -> DONE with abort, watchdog and errors
module sgd_run_ctrl #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int FEAT_W       = 4,
  parameter int EPOCH_W      = 8,
  parameter int LR_W         = 4,
  parameter int TIMEOUT_W    = 24
) (
  input logic           CLK,
  input logic           RST,
  sgd_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TRAIN = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [FEAT_W:0]      MAX_F   = MAX_FEATURES[FEAT_W:0];
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = TIMEOUT_W'(1);
  // Firing one count early means the edge that would make the counter all-ones leaves the state.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = ~WD_ONE;

  state_t                r_state;
  state_t                w_next;
  logic                  r_loaded;
  logic [TIMEOUT_W-1:0]  r_wdog;
  logic [1:0]            r_err_code;
  logic [FEAT_W-1:0]     r_lat_feat;
  logic [EPOCH_W-1:0]    r_lat_epoch;
  logic [LR_W-1:0]       r_lat_lr;
  logic [ADDR_WIDTH-1:0] r_lat_num_dp;

  logic                  w_can_start;
  logic                  w_accept;
  logic                  w_cfg_bad;
  logic                  w_no_data;
  logic                  w_timeout;
  logic                  w_active;
  logic                  w_tmo_err;
  logic                  w_ram_we;
  logic                  w_ram_oe;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic                  w_ser_en;
  logic                  w_sgd_en;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_err;

  assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_accept    = w_can_start && bus.start;
  assign w_cfg_bad   = (bus.cfg_num_dp == '0) || (bus.cfg_feat == '0) ||
                       ({1'b0, bus.cfg_feat} > MAX_F);
  assign w_no_data   = bus.skip_load && !r_loaded;
  assign w_active    = (r_state == S_LOAD) || (r_state == S_TRAIN);
  assign w_timeout   = w_active && (r_wdog == WD_LAST);
  assign w_tmo_err   = w_active && (w_next == S_ERR);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Priority inside each busy state: abort, then the done level, then the watchdog.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          if (w_cfg_bad || w_no_data) w_next = S_ERR;
          else if (bus.skip_load)     w_next = S_TRAIN;
          else                        w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.abort)         w_next = S_IDLE;
        else if (bus.ser_done) w_next = S_TRAIN;
        else if (w_timeout)    w_next = S_ERR;
      end
      S_TRAIN: begin
        if (bus.abort)         w_next = S_IDLE;
        else if (bus.sgd_done) w_next = S_WB;
        else if (w_timeout)    w_next = S_ERR;
      end
      S_WB: begin
        if (bus.abort) w_next = S_IDLE;
        else           w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ram_we   = 1'b0;
    w_ram_oe   = 1'b0;
    w_ram_addr = '0;
    w_ser_en   = 1'b0;
    w_sgd_en   = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_ser_en   = 1'b1;
        w_busy     = 1'b1;
        w_ram_addr = bus.ser_addr;
        w_ram_we   = bus.ser_wr_req && !bus.ser_done && !RST;
      end
      S_TRAIN: begin
        w_sgd_en   = 1'b1;
        w_busy     = 1'b1;
        w_ram_addr = bus.sgd_addr;
        w_ram_oe   = 1'b1;
      end
      S_WB: begin
        w_sgd_en   = 1'b1;
        w_busy     = 1'b1;
        w_ram_addr = bus.sgd_addr;
        w_ram_we   = !RST;
      end
      S_DONE: begin
        w_sgd_en = 1'b1;
        w_done   = 1'b1;
      end
      S_ERR:   w_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_loaded     <= 1'b0;
      r_wdog       <= '0;
      r_err_code   <= 2'd0;
      r_lat_feat   <= '0;
      r_lat_epoch  <= '0;
      r_lat_lr     <= '0;
      r_lat_num_dp <= '0;
    end else begin
      if (w_next != r_state) r_wdog <= '0;
      else if (w_active)     r_wdog <= r_wdog + WD_ONE;

      if (w_accept) begin
        r_lat_feat   <= bus.cfg_feat;
        r_lat_epoch  <= bus.cfg_epoch;
        r_lat_lr     <= bus.cfg_lr;
        r_lat_num_dp <= bus.cfg_num_dp;
        if (w_cfg_bad)      r_err_code <= 2'd1;
        else if (w_no_data) r_err_code <= 2'd2;
        else                r_err_code <= 2'd0;
        if (!w_cfg_bad && !bus.skip_load) r_loaded <= 1'b0;
      end

      if (r_state == S_LOAD && bus.abort)                       r_loaded <= 1'b0;
      else if (r_state == S_LOAD && w_next == S_TRAIN)          r_loaded <= 1'b1;
      if (w_tmo_err) begin
        r_loaded   <= 1'b0;
        r_err_code <= 2'd3;
      end
    end
  end

  assign bus.ram_we     = w_ram_we;
  assign bus.ram_oe     = w_ram_oe;
  assign bus.ram_addr   = w_ram_addr;
  assign bus.ser_en     = w_ser_en;
  assign bus.sgd_en     = w_sgd_en;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.err        = w_err;
  assign bus.err_code   = r_err_code;
  assign bus.state      = r_state;
  assign bus.lat_feat   = r_lat_feat;
  assign bus.lat_epoch  = r_lat_epoch;
  assign bus.lat_lr     = r_lat_lr;
  assign bus.lat_num_dp = r_lat_num_dp;

endmodule

// File: tb/tb_sgd_run_ctrl.sv
// tb/tb_sgd_run_ctrl.sv - directed plus random checks of sgd_run_ctrl against a run-level model
module tb_sgd_run_ctrl;
  localparam int AW   = 12;
  localparam int MAXF = 12;
  localparam int FW   = 4;
  localparam int EW   = 8;
  localparam int LW   = 4;
  localparam int TW   = 6;
  localparam int TMO  = (1 << TW) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  sgd_run_ctrl_if #(.ADDR_WIDTH(AW), .FEAT_W(FW), .EPOCH_W(EW), .LR_W(LW)) bus ();

  sgd_run_ctrl #(
    .ADDR_WIDTH(AW), .MAX_FEATURES(MAXF), .FEAT_W(FW),
    .EPOCH_W(EW), .LR_W(LW), .TIMEOUT_W(TW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int          m_state;
  bit          m_loaded;
  int          m_code;
  int          m_tin;
  logic [31:0] m_lat;

  int          wr_cnt;
  logic [31:0] wr_addr;
  int          seq[$];
  int          prev_st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.abort = 0; bus.skip_load = 0;
    bus.cfg_feat = 4'd3; bus.cfg_epoch = 8'd2; bus.cfg_lr = 4'd1; bus.cfg_num_dp = 12'd4;
    bus.ser_done = 0; bus.ser_wr_req = 0; bus.ser_addr = '0;
    bus.sgd_done = 0; bus.sgd_addr = '0;
  endtask

  task automatic model_reset();
    m_state = 0; m_loaded = 0; m_code = 0; m_tin = 0; m_lat = '0;
  endtask

  task automatic model_step();
    int nxt;
    bit bad;
    nxt = m_state;
    if (RST) begin
      model_reset();
      return;
    end
    case (m_state)
      0, 4, 5: if (bus.start) begin
        m_lat = {4'(bus.cfg_feat), 8'(bus.cfg_epoch), 4'(bus.cfg_lr), 12'(bus.cfg_num_dp)};
        bad = (int'(bus.cfg_num_dp) == 0) || (int'(bus.cfg_feat) == 0) || (int'(bus.cfg_feat) > MAXF);
        m_code = 0;
        if (bad)                               begin nxt = 5; m_code = 1; end
        else if (bus.skip_load && !m_loaded)   begin nxt = 5; m_code = 2; end
        else if (bus.skip_load)                nxt = 2;
        else                                   begin nxt = 1; m_loaded = 0; end
      end
      1: begin
        if (bus.abort)               begin nxt = 0; m_loaded = 0; end
        else if (bus.ser_done)       begin nxt = 2; m_loaded = 1; end
        else if (m_tin + 1 == TMO)   begin nxt = 5; m_code = 3; m_loaded = 0; end
      end
      2: begin
        if (bus.abort)               nxt = 0;
        else if (bus.sgd_done)       nxt = 3;
        else if (m_tin + 1 == TMO)   begin nxt = 5; m_code = 3; m_loaded = 0; end
      end
      3: nxt = bus.abort ? 0 : 4;
      default: nxt = 0;
    endcase
    m_tin   = (nxt == m_state) ? m_tin + 1 : 0;
    m_state = nxt;
  endtask

  task automatic tick();
    bit          e_we;
    logic [31:0] e_addr;
    logic [4:0]  e_fl;
    @(negedge CLK);
    e_we   = !RST && ((m_state == 1 && bus.ser_wr_req && !bus.ser_done) || m_state == 3);
    e_addr = (m_state == 1) ? 32'(bus.ser_addr) :
             (m_state == 2 || m_state == 3) ? 32'(bus.sgd_addr) : 32'd0;
    e_fl   = {m_state == 1, m_state inside {2, 3, 4}, m_state inside {1, 2, 3}, m_state == 4, m_state == 5};
    chk("state", 32'(bus.state), m_state);
    chk("ram_we", 32'(bus.ram_we), 32'(e_we));
    chk("ram_oe", 32'(bus.ram_oe), 32'(m_state == 2));
    chk("ram_addr", 32'(bus.ram_addr), e_addr);
    chk("flags", 32'({bus.ser_en, bus.sgd_en, bus.busy, bus.done, bus.err}), 32'(e_fl));
    chk("err_code", 32'(bus.err_code), m_code);
    chk("lat", 32'({bus.lat_feat, bus.lat_epoch, bus.lat_lr, bus.lat_num_dp}), m_lat);
    if (bus.ram_we) begin
      wr_cnt++;
      wr_addr = 32'(bus.ram_addr);
    end
    if (int'(bus.state) != prev_st) begin
      seq.push_back(int'(bus.state));
      prev_st = int'(bus.state);
    end
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic go(input bit skip);
    bus.skip_load = skip;
    bus.start = 1;
    tick();
    bus.start = 0;
    bus.skip_load = 0;
  endtask

  initial begin
    int n;
    clear_inputs();
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    prev_st = 0;
    tick();
    RST = 0;
    chk("reset_state", 32'(bus.state), 0);
    chk("reset_flags", 32'({bus.ser_en, bus.sgd_en, bus.busy, bus.done, bus.err}), 0);

    // Normal run: 4 loader writes then one writeback at the engine address.
    wr_cnt = 0; seq.delete();
    go(0);
    for (int i = 0; i < 4; i++) begin
      bus.ser_wr_req = 1; bus.ser_addr = 12'(i + 8);
      tick();
    end
    bus.ser_wr_req = 1; bus.ser_done = 1;
    tick();
    bus.ser_wr_req = 0; bus.ser_done = 0; bus.sgd_addr = 12'h055;
    repeat (50) tick();
    bus.sgd_done = 1;
    tick();
    bus.sgd_done = 0;
    repeat (2) tick();
    chk("run_writes", 32'(wr_cnt), 5);
    chk("wb_addr", wr_addr, 32'h055);
    chk("seq_len", 32'(seq.size()), 4);
    for (int i = 0; i < seq.size() && i < 4; i++) chk("seq", 32'(seq[i]), 32'(i + 1));
    chk("done", 32'(bus.done), 1);

    // Retrain without reload.
    bus.cfg_epoch = 8'd7;
    go(1);
    chk("retrain_state", 32'(bus.state), 2);
    chk("retrain_epoch", 32'(bus.lat_epoch), 7);
    bus.sgd_done = 1;
    tick();
    bus.sgd_done = 0;
    repeat (2) tick();
    chk("retrain_done", 32'(bus.state), 4);

    // Config errors after reset.
    RST = 1; tick(); RST = 0;
    wr_cnt = 0;
    go(1);
    chk("nodata_code", 32'(bus.err_code), 2);
    bus.cfg_feat = 4'd0;
    go(0);
    chk("feat0_code", 32'(bus.err_code), 1);
    bus.cfg_feat = 4'd13;
    go(0);
    chk("featmax_code", 32'(bus.err_code), 1);
    bus.cfg_feat = 4'd3; bus.cfg_num_dp = 12'd0;
    go(0);
    chk("numdp0_code", 32'(bus.err_code), 1);
    bus.cfg_num_dp = 12'd4;
    chk("err_writes", 32'(wr_cnt), 0);

    // Watchdog in LOAD.
    go(0);
    n = 0;
    while (bus.state == 3'd1 && n < 200) begin
      tick();
      n++;
    end
    chk("tmo_cycles", 32'(n), TMO);
    chk("tmo_code", 32'(bus.err_code), 3);

    // abort beats sgd_done in the same TRAIN cycle.
    go(0);
    bus.ser_done = 1; tick(); bus.ser_done = 0;
    repeat (3) tick();
    wr_cnt = 0;
    bus.abort = 1; bus.sgd_done = 1;
    tick();
    bus.abort = 0; bus.sgd_done = 0;
    chk("abort_state", 32'(bus.state), 0);
    tick();
    chk("abort_writes", 32'(wr_cnt), 0);

    // Reset in LOAD with a pending write.
    go(0);
    wr_cnt = 0;
    bus.ser_wr_req = 1; RST = 1;
    tick();
    RST = 0; bus.ser_wr_req = 0;
    chk("midrst_state", 32'(bus.state), 0);
    chk("midrst_writes", 32'(wr_cnt), 0);
    go(1);
    chk("midrst_code", 32'(bus.err_code), 2);

    for (int c = 0; c < 3000; c++) begin
      RST            = ($urandom % 300) == 0;
      bus.start      = ($urandom % 8) == 0;
      bus.abort      = ($urandom % 40) == 0;
      bus.skip_load  = $urandom % 2;
      bus.cfg_feat   = FW'($urandom);
      bus.cfg_epoch  = EW'($urandom);
      bus.cfg_lr     = LW'($urandom);
      bus.cfg_num_dp = (($urandom % 8) == 0) ? '0 : AW'($urandom);
      bus.ser_wr_req = $urandom % 2;
      bus.ser_addr   = AW'($urandom);
      bus.ser_done   = ($urandom % 12) == 0;
      bus.sgd_done   = ($urandom % 15) == 0;
      bus.sgd_addr   = AW'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
